usb_crc16_chk: RTL and testbench
================================

Name: usb_crc16_chk

Overview:
Receive-side CRC16 checker for USB DATA packets. It is the counterpart of the transmit-side CRC16 generator.
- Accepts the de-stuffed byte stream after the PID: payload bytes followed by the 2-byte CRC field.
- Forwards payload bytes only, with the CRC field stripped.
- At end of packet, reports CRC pass/fail and payload length to the receive controller.

Parameters:
MAX_PAYLOAD, 1023, largest legal payload length in bytes; a longer payload raises len_err.
CNT_W, 11, width of byte_cnt; must satisfy 2^CNT_W > MAX_PAYLOAD.

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
rx_sop  in  1  start-of-packet strobe; clears checker state
rx_data  in  8  received byte, LSB was first on the wire
rx_valid  in  1  rx_data is valid this cycle
rx_eop  in  1  end-of-packet strobe
pl_data  out  8  payload byte (CRC field stripped)
pl_valid  out  1  pl_data valid, one-cycle strobe
pkt_done  out  1  one-cycle strobe: status outputs now valid
crc_ok  out  1  CRC matched; held until next rx_sop
crc_err  out  1  CRC mismatch, short packet, or length error; held until next rx_sop
short_err  out  1  fewer than 2 bytes received; held until next rx_sop
len_err  out  1  payload longer than MAX_PAYLOAD; held until next rx_sop
byte_cnt  out  CNT_W  payload byte count (CRC bytes excluded); saturates at all-ones

Behaviour:
- Reset: every output is 0; state IDLE; CRC register 0xFFFF; delay buffer empty.
- CRC engine:
  - Polynomial x^16+x^15+x^2+1, reflected, byte-parallel.
  - Data is consumed LSB-first; initial value 0xFFFF.
  - The engine is fed only bytes leaving the delay buffer, i.e. payload bytes.
- Expected CRC field is ~crc, transmitted low byte first.
- 2-byte delay buffer (buf0 older, buf1 newer, fill count 0..2):
  - An accepted byte with fill count 2 pushes buf0 out as payload.
  - On the next cycle, pl_data = that byte and pl_valid = 1.
  - byte_cnt increments and the CRC updates on the same edge.
  - Pipeline latency from rx_valid to pl_valid is 1 cycle, from the third byte onward.
- States:
  - IDLE: rx_valid and rx_eop are ignored; rx_sop → RX.
  - RX:
    - rx_valid accepts a byte.
    - rx_eop → DONE.
    - rx_sop aborts the packet (no pkt_done), clears state, and stays in RX.
  - DONE, one cycle:
    - Compares {buf1,buf0} with ~crc; requires fill == 2.
    - Registers the status outputs and moves to IDLE.
    - pkt_done pulses in the cycle after DONE, i.e. 2 edges after the edge that samples rx_eop.
    - rx_valid in DONE is ignored.
- rx_sop in any state:
  - Clears crc_ok, crc_err, short_err, len_err, byte_cnt, buffer and CRC on that edge.
  - Next state is RX.
- Simultaneous events:
  - rx_sop with rx_valid: the byte becomes the first byte of the new packet.
  - rx_valid with rx_eop: the byte is accepted as the last byte, then eop is processed.
  - rx_sop with rx_eop: rx_sop wins; eop is ignored.
- Status rules:
  - Fill < 2 at DONE: short_err = 1, crc_err = 1, crc_ok = 0.
  - byte_cnt > MAX_PAYLOAD: len_err = 1, crc_err = 1, crc_ok = 0; payload is still forwarded.
  - Otherwise: crc_ok = match, crc_err = !match.
  - crc_ok and crc_err are never both 1.
- Reset asserted mid-packet: immediate return to reset values; no pkt_done.

Optional Feature:
Macro: USB_CRC16_ERR_CNT_EN
- Defined:
  - Adds output err_count [15:0], reset 0.
  - Increments, saturating at 0xFFFF, in the same cycle pkt_done pulses with crc_err = 1.
  - Not cleared by rx_sop.
- Undefined: no port, no counter logic; all other behaviour is identical.

Test Plan:
- Zero-length packet: sop, bytes 0x00 0x00, eop → no pl_valid, byte_cnt = 0, pkt_done with crc_ok = 1.
- ASCII "123456789" (0x31..0x39), then 0xC8 0xB4, eop → 9 pl_valid strobes in order 0x31..0x39, byte_cnt = 9, crc_ok = 1.
- Same packet with the last CRC byte 0xB5 → crc_err = 1, crc_ok = 0, short_err = 0; err_count = 1 when USB_CRC16_ERR_CNT_EN is defined.
- Single byte 0x5A then eop → short_err = 1, crc_err = 1, no pl_valid; then rx_eop alone in IDLE → no pkt_done.
- Abort/overlap:
  - sop, 4 bytes, then sop with byte 0x00, then 0x00, eop → only one pkt_done, crc_ok = 1, byte_cnt = 0.
  - rx_valid + rx_eop in the same cycle on the final CRC byte → crc_ok = 1.
- MAX_PAYLOAD = 4: 5 payload bytes plus a correct CRC → len_err = 1, crc_err = 1, 5 pl_valid strobes.
- n_rst pulsed mid-packet → all outputs 0 immediately, no pkt_done.

Source files
------------

// File: rtl/usb_crc16_chk.sv
// Receive-side CRC16 checker for USB DATA packets: strips the trailing CRC field, forwards payload, reports status.
// Optional error counter output enabled by defining USB_CRC16_ERR_CNT_EN.
module usb_crc16_chk #(
    parameter int MAX_PAYLOAD = 1023,
    parameter int CNT_W       = 11
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             rx_sop,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             rx_eop,
    output logic [7:0]       pl_data,
    output logic             pl_valid,
    output logic             pkt_done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             short_err,
    output logic             len_err,
    output logic [CNT_W-1:0] byte_cnt
`ifdef USB_CRC16_ERR_CNT_EN
    ,
    output logic [15:0]      err_count
`endif
);

    localparam logic [15:0]      CRC_POLY = 16'hA001;
    localparam logic [15:0]      CRC_INIT = 16'hFFFF;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PAYLOAD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RX   = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [7:0]       r_buf0;
    logic [7:0]       r_buf1;
    logic [1:0]       r_fill;
    logic [15:0]      r_crc;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [7:0]       r_pl_data;
    logic             r_pl_valid;
    logic             r_pkt_done;
    logic             r_crc_ok;
    logic             r_crc_err;
    logic             r_short_err;
    logic             r_len_err;

    logic             w_accept;
    logic             w_eval;
    logic             w_push_out;
    logic [15:0]      w_crc_next;
    logic             w_short;
    logic             w_len;
    logic             w_match;
    logic             w_bad;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a start strobe always (re)starts reception
    always_comb begin
        w_state_next = r_state;
        if (rx_sop) begin
            w_state_next = S_RX;
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = S_IDLE;
                S_RX:    w_state_next = rx_eop ? S_DONE : S_RX;
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Control decode: a byte arriving with sop is the first byte of the new packet
    always_comb begin
        w_accept   = 1'b0;
        w_eval     = 1'b0;
        w_push_out = 1'b0;
        if (rx_valid && (rx_sop || (r_state == S_RX))) begin
            w_accept = 1'b1;
        end
        if (!rx_sop && (r_state == S_DONE)) begin
            w_eval = 1'b1;
        end
        if (!rx_sop && w_accept && (r_fill == 2'd2)) begin
            w_push_out = 1'b1;
        end
    end

    // Byte-parallel reflected CRC update of the byte leaving the delay buffer
    for (genvar gi = 0; gi < 8; gi++) begin : g_crc_bit
        logic [15:0] w_in;
        logic [15:0] w_out;
        if (gi == 0) begin : g_first
            assign w_in = r_crc ^ {8'h00, r_buf0};
        end else begin : g_rest
            assign w_in = g_crc_bit[gi-1].w_out;
        end
        assign w_out = w_in[0] ? ((w_in >> 1) ^ CRC_POLY) : (w_in >> 1);
    end
    assign w_crc_next = g_crc_bit[7].w_out;

    // The last two bytes held in the buffer are the CRC field, low byte first
    assign w_short = (r_fill != 2'd2);
    assign w_len   = (r_byte_cnt > MAX_CNT);
    assign w_match = ({r_buf1, r_buf0} == ~r_crc);
    assign w_bad   = w_short || w_len || !w_match;

    // Delay buffer, payload forwarding, CRC and byte count
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_buf0     <= 8'h00;
            r_buf1     <= 8'h00;
            r_fill     <= 2'd0;
            r_crc      <= CRC_INIT;
            r_byte_cnt <= '0;
            r_pl_data  <= 8'h00;
            r_pl_valid <= 1'b0;
        end else begin
            r_pl_valid <= 1'b0;
            if (rx_sop) begin
                r_crc      <= CRC_INIT;
                r_byte_cnt <= '0;
                if (w_accept) begin
                    r_buf0 <= rx_data;
                    r_fill <= 2'd1;
                end else begin
                    r_fill <= 2'd0;
                end
            end else if (w_accept) begin
                case (r_fill)
                    2'd0: begin
                        r_buf0 <= rx_data;
                        r_fill <= 2'd1;
                    end
                    2'd1: begin
                        r_buf1 <= rx_data;
                        r_fill <= 2'd2;
                    end
                    default: begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= rx_data;
                    end
                endcase
            end
            if (w_push_out) begin
                r_pl_data  <= r_buf0;
                r_pl_valid <= 1'b1;
                r_crc      <= w_crc_next;
                if (r_byte_cnt != '1) begin
                    r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                end
            end
        end
    end

    // End-of-packet status, held until the next start strobe
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pkt_done  <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_crc_err   <= 1'b0;
            r_short_err <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            if (rx_sop) begin
                r_crc_ok    <= 1'b0;
                r_crc_err   <= 1'b0;
                r_short_err <= 1'b0;
                r_len_err   <= 1'b0;
            end else if (w_eval) begin
                r_pkt_done  <= 1'b1;
                r_crc_ok    <= !w_bad;
                r_crc_err   <= w_bad;
                r_short_err <= w_short;
                r_len_err   <= w_len && !w_short;
            end
        end
    end

`ifdef USB_CRC16_ERR_CNT_EN
    logic [15:0] r_err_count;

    // Lifetime count of failed packets; survives start strobes
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_err_count <= 16'h0000;
        end else if (w_eval && w_bad && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign pl_data   = r_pl_data;
    assign pl_valid  = r_pl_valid;
    assign pkt_done  = r_pkt_done;
    assign crc_ok    = r_crc_ok;
    assign crc_err   = r_crc_err;
    assign short_err = r_short_err;
    assign len_err   = r_len_err;
    assign byte_cnt  = r_byte_cnt;

endmodule

// File: tb/tb_usb_crc16_chk.sv
// Scoreboard bench for usb_crc16_chk: payload bytes and end-of-packet status are queued
// when stimulus is driven and compared when the DUT strobes pl_valid / pkt_done.
module tb_usb_crc16_chk;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        rx_sop = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_eop = 1'b0;

    logic [7:0]  pl_data;
    logic        pl_valid, pkt_done, crc_ok, crc_err, short_err, len_err;
    logic [10:0] byte_cnt;

    logic [7:0]  s_pl_data;
    logic        s_pl_valid, s_pkt_done, s_crc_ok, s_crc_err, s_short_err, s_len_err;
    logic [10:0] s_byte_cnt;

`ifdef USB_CRC16_ERR_CNT_EN
    logic [15:0] err_count, s_err_count;
    int          exp_err = 0;
`endif

    usb_crc16_chk #(.MAX_PAYLOAD(1023), .CNT_W(11)) u_dut (
        .clk(clk), .n_rst(n_rst), .rx_sop(rx_sop), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_eop(rx_eop), .pl_data(pl_data), .pl_valid(pl_valid),
        .pkt_done(pkt_done), .crc_ok(crc_ok), .crc_err(crc_err), .short_err(short_err),
        .len_err(len_err), .byte_cnt(byte_cnt)
`ifdef USB_CRC16_ERR_CNT_EN
        , .err_count(err_count)
`endif
    );

    usb_crc16_chk #(.MAX_PAYLOAD(4), .CNT_W(11)) u_dut_small (
        .clk(clk), .n_rst(n_rst), .rx_sop(rx_sop), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_eop(rx_eop), .pl_data(s_pl_data), .pl_valid(s_pl_valid),
        .pkt_done(s_pkt_done), .crc_ok(s_crc_ok), .crc_err(s_crc_err), .short_err(s_short_err),
        .len_err(s_len_err), .byte_cnt(s_byte_cnt)
`ifdef USB_CRC16_ERR_CNT_EN
        , .err_count(s_err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ok;
        logic        err;
        logic        sh;
        logic        ln;
        logic [10:0] cnt;
    } status_t;

    logic [7:0] pl_q[$];
    status_t    st_q[$];
    int         checks = 0;
    int         failures = 0;

    int   s_pl_n = 0;
    int   s_done_n = 0;
    logic s_ok_l = 1'b0, s_err_l = 1'b0, s_len_l = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference CRC over the payload, returned already inverted
    function automatic logic [15:0] ref_crc(input logic [7:0] d[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (d[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return ~c;
    endfunction

    task automatic expect_pkt(input logic [7:0] b[$], input bit complete);
        logic [7:0]  pay[$];
        status_t     st;
        logic [15:0] exp_crc;
        int          n;
        n = b.size();
        for (int i = 0; i < n - 2; i++) begin
            pl_q.push_back(b[i]);
            pay.push_back(b[i]);
        end
        if (complete) begin
            st.sh  = (n < 2);
            st.cnt = (n >= 2) ? 11'(n - 2) : 11'd0;
            st.ln  = (n >= 2) && (n - 2 > 1023);
            exp_crc = ref_crc(pay);
            st.ok  = !st.sh && !st.ln && ({b[n-1], b[n-2]} == exp_crc);
            st.err = !st.ok;
            st_q.push_back(st);
        end
    endtask

    task automatic cyc(input logic s, input logic v, input logic [7:0] d, input logic e);
        rx_sop   = s;
        rx_valid = v;
        rx_data  = d;
        rx_eop   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 8 && st_q.size() != 0; i++) @(posedge clk);
        #1;
        check("pkt_done_seen", st_q.size(), 0);
        check("pl_drained", pl_q.size(), 0);
    endtask

    task automatic send(input logic [7:0] b[$], input bit eop_on_last, input bit sop_with_first);
        int n;
        n = b.size();
        expect_pkt(b, 1'b1);
        if (!sop_with_first) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < n; i++)
            cyc(sop_with_first && (i == 0), 1'b1, b[i], eop_on_last && (i == n - 1));
        if (!eop_on_last) cyc(1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        wait_done();
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (pl_valid) begin
            if (pl_q.size() == 0) begin
                check("pl_unexpected", pl_valid, 1'b0);
            end else begin
                logic [7:0] e;
                e = pl_q.pop_front();
                check("pl_data", pl_data, e);
                $display("pl_valid data=0x%02h", pl_data);
            end
        end
        if (pkt_done) begin
            if (st_q.size() == 0) begin
                check("pkt_done_unexpected", pkt_done, 1'b0);
            end else begin
                status_t s;
                s = st_q.pop_front();
                check("crc_ok", crc_ok, s.ok);
                check("crc_err", crc_err, s.err);
                check("short_err", short_err, s.sh);
                check("len_err", len_err, s.ln);
                check("byte_cnt", byte_cnt, s.cnt);
                check("ok_err_excl", crc_ok & crc_err, 1'b0);
`ifdef USB_CRC16_ERR_CNT_EN
                if (s.err) exp_err++;
                check("err_count", err_count, exp_err);
`endif
                $display("pkt_done ok=%0b err=%0b short=%0b len=%0b cnt=%0d",
                         crc_ok, crc_err, short_err, len_err, byte_cnt);
            end
        end
        if (s_pl_valid) s_pl_n++;
        if (s_pkt_done) begin
            s_done_n++;
            s_ok_l  = s_crc_ok;
            s_err_l = s_crc_err;
            s_len_l = s_len_err;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  pkt[$];
        logic [7:0]  pay[$];
        logic [15:0] c;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pl_valid", pl_valid, 1'b0);
        check("rst_pl_data", pl_data, 8'h00);
        check("rst_pkt_done", pkt_done, 1'b0);
        check("rst_crc_ok", crc_ok, 1'b0);
        check("rst_crc_err", crc_err, 1'b0);
        check("rst_short_err", short_err, 1'b0);
        check("rst_len_err", len_err, 1'b0);
        check("rst_byte_cnt", byte_cnt, 11'd0);
        n_rst = 1'b1;
        cyc(1'b0, 1'b0, 8'h00, 1'b0);

        // Zero-length packet
        pkt = '{8'h00, 8'h00};
        send(pkt, 1'b0, 1'b0);

        // "123456789" with correct CRC, status must hold afterwards
        pkt = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
        send(pkt, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("crc_ok_held", crc_ok, 1'b1);
        check("byte_cnt_held", byte_cnt, 11'd9);

        // Corrupted last CRC byte
        pkt[10] = 8'hB5;
        send(pkt, 1'b0, 1'b0);

        // Single byte -> short; eop alone in IDLE must not pulse pkt_done
        pkt = '{8'h5A};
        send(pkt, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h11, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("short_held", short_err, 1'b1);
        check("crc_err_held", crc_err, 1'b1);

        // Aborted packet, then restart with sop carrying the first byte
        pkt = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        expect_pkt(pkt, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        foreach (pkt[i]) cyc(1'b0, 1'b1, pkt[i], 1'b0);
        pkt = '{8'h00, 8'h00};
        send(pkt, 1'b1, 1'b1);

        // Final CRC byte together with eop
        pkt = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
        send(pkt, 1'b1, 1'b0);

        // 5-byte payload: fine for the default build, too long for MAX_PAYLOAD=4
        pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        c = ref_crc(pay);
        pkt = pay;
        pkt.push_back(c[7:0]);
        pkt.push_back(c[15:8]);
        s_pl_n = 0;
        s_done_n = 0;
        send(pkt, 1'b0, 1'b0);
        check("small_pl_count", s_pl_n, 5);
        check("small_done_count", s_done_n, 1);
        check("small_len_err", s_len_l, 1'b1);
        check("small_crc_err", s_err_l, 1'b1);
        check("small_crc_ok", s_ok_l, 1'b0);

        // Reset asserted mid-packet
        pl_q.push_back(8'hC1);
        pl_q.push_back(8'hC2);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 8'hC1, 1'b0);
        cyc(1'b0, 1'b1, 8'hC2, 1'b0);
        cyc(1'b0, 1'b1, 8'hC3, 1'b0);
        cyc(1'b0, 1'b1, 8'hC4, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("cnt_pre_rst", byte_cnt, 11'd2);
        rx_valid = 1'b1;
        rx_data  = 8'hC5;
        rx_eop   = 1'b1;
        n_rst    = 1'b0;
`ifdef USB_CRC16_ERR_CNT_EN
        exp_err  = 0;
`endif
        #1;
        check("mid_rst_byte_cnt", byte_cnt, 11'd0);
        check("mid_rst_pl_valid", pl_valid, 1'b0);
        check("mid_rst_pkt_done", pkt_done, 1'b0);
        check("mid_rst_crc_ok", crc_ok, 1'b0);
        check("mid_rst_crc_err", crc_err, 1'b0);
        check("mid_rst_pl_data", pl_data, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_eop   = 1'b0;
        n_rst    = 1'b1;
        repeat (4) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check("post_rst_byte_cnt", byte_cnt, 11'd0);

        // Recovery after reset
        pkt = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
        send(pkt, 1'b0, 1'b0);

        check("pl_q_empty", pl_q.size(), 0);
        check("st_q_empty", st_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
